// File: rtl/mcs4_cycle_ctrl.sv
// Two-phase clock-enable and instruction-cycle sequencer for the MCS-4 system.
// Steps the eight 4004 subcycles and supports run, halt and single instruction-cycle step.
module mcs4_cycle_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    input  logic             halt_i,
    input  logic             step_i,
    output logic             clken_1,
    output logic             clken_2,
    output logic             sync,
    output logic [2:0]       subcycle,
    output logic             running,
    output logic [CNT_W-1:0] icycle_cnt
);

    localparam int T_W = ($clog2(2 * CLK_DIV) < 1) ? 1 : $clog2(2 * CLK_DIV);
    localparam logic [T_W-1:0] T_LAST = T_W'(2 * CLK_DIV - 1);
    localparam logic [T_W-1:0] T_HALF = T_W'(CLK_DIV);
    localparam logic [T_W-1:0] T_ZERO = {T_W{1'b0}};

    typedef enum logic [1:0] {
        ST_HALTED = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [T_W-1:0]   t_r;
    logic [T_W-1:0]   t_s;
    logic [2:0]       s_r;
    logic [2:0]       s_s;
    logic             stop_pending_r;
    logic             stop_pending_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             last_tick_s;
    logic             boundary_s;
    logic             stop_req_s;
    logic             active_s;

    // Next-state computation for the sequencer and its counters.
    always_comb begin
        state_s        = state_r;
        t_s            = t_r;
        s_s            = s_r;
        stop_pending_s = stop_pending_r;
        cnt_s          = cnt_r;
        last_tick_s    = (t_r == T_LAST);
        boundary_s     = last_tick_s && (s_r == 3'd7);
        stop_req_s     = halt_i || !run_i;

        case (state_r)
            ST_HALTED: begin
                t_s            = T_ZERO;
                s_s            = 3'd0;
                stop_pending_s = 1'b0;
                if (halt_i) begin
                    state_s = ST_HALTED;
                end else if (run_i) begin
                    state_s = ST_RUN;
                end else if (step_i) begin
                    state_s = ST_STEP;
                end else begin
                    state_s = ST_HALTED;
                end
            end
            ST_RUN, ST_STEP: begin
                if (last_tick_s) begin
                    t_s = T_ZERO;
                    s_s = s_r + 3'd1;
                end else begin
                    t_s = t_r + T_W'(1);
                    s_s = s_r;
                end
                if (boundary_s) begin
                    cnt_s          = cnt_r + CNT_W'(1);
                    stop_pending_s = 1'b0;
                    // A stop request seen on the boundary clock itself still counts.
                    if (state_r == ST_STEP || stop_pending_r || stop_req_s) begin
                        state_s = ST_HALTED;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else if (state_r == ST_RUN) begin
                    stop_pending_s = stop_pending_r || stop_req_s;
                end else begin
                    stop_pending_s = 1'b0;
                end
            end
            default: begin
                state_s        = ST_HALTED;
                t_s            = T_ZERO;
                s_s            = 3'd0;
                stop_pending_s = 1'b0;
            end
        endcase

        active_s = (state_s != ST_HALTED);
    end

    // State, counters and outputs decoded from the next register values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= ST_HALTED;
            t_r            <= T_ZERO;
            s_r            <= 3'd0;
            stop_pending_r <= 1'b0;
            cnt_r          <= {CNT_W{1'b0}};
            clken_1        <= 1'b0;
            clken_2        <= 1'b0;
            sync           <= 1'b0;
            subcycle       <= 3'd0;
            running        <= 1'b0;
        end else begin
            state_r        <= state_s;
            t_r            <= t_s;
            s_r            <= s_s;
            stop_pending_r <= stop_pending_s;
            cnt_r          <= cnt_s;
            clken_1        <= active_s && (t_s == T_ZERO);
            clken_2        <= active_s && (t_s == T_HALF);
            sync           <= active_s && (s_s == 3'd7);
            subcycle       <= s_s;
            running        <= active_s;
        end
    end

    assign icycle_cnt = cnt_r;

endmodule

// File: doc/mcs4_cycle_ctrl.md
# mcs4_cycle_ctrl

Two-phase clock-enable and instruction-cycle sequencer for the MCS-4 system. It generates `clken_1`, `clken_2` and `sync` for the i4004, i4001 and i4002 instances. It derives them from the single fabric clock and steps through the eight 4004 subcycles (A1 A2 A3 M1 M2 X1 X2 X3). A run/halt/single-step front end lets the PYNQ host free-run the system or advance it one instruction cycle at a time; halts land only on instruction-cycle boundaries.

## Interface

Parameters:

- `CLK_DIV`, default 4: fabric clocks per clock phase; one subcycle = 2·`CLK_DIV` clocks. Legal range ≥ 1.
- `CNT_W`, default 16: width of the instruction-cycle counter.

Ports:

- `clk`, input, 1: fabric clock. This is the only clock in the block.
- `rst`, input, 1: reset, asynchronous, active-low.
- `run_i`, input, 1: level. Request continuous running.
- `halt_i`, input, 1: level. Request stop at the next boundary. Has priority over `run_i` and `step_i`.
- `step_i`, input, 1: single-clock pulse. Run exactly one instruction cycle.
- `clken_1`, output, 1: one-clock phase-1 enable, once per subcycle.
- `clken_2`, output, 1: one-clock phase-2 enable, once per subcycle.
- `sync`, output, 1: high for the whole X3 subcycle.
- `subcycle`, output, 3: current subcycle. 0 = A1 … 7 = X3.
- `running`, output, 1: high in RUN or STEP.
- `icycle_cnt`, output, `CNT_W`: count of completed instruction cycles.

## Operation

- State machine has three states: HALTED, RUN, STEP.
- Registers:
  - tick counter `t`, 0..2·`CLK_DIV`−1;
  - subcycle counter `s`, 0..7;
  - `stop_pending`;
  - `icycle_cnt`.
- Every output is decoded from registers only. There is no combinational path from any input to any output.
- Definitions:
  - `last_tick` = (`t` = 2·`CLK_DIV`−1);
  - `boundary` = `last_tick` and `s` = 7.
- HALTED:
  - `t` = 0, `s` = 0, all enables low.
  - If `halt_i` is high, stay.
  - Else if `run_i` is high, go to RUN.
  - Else if `step_i` is high, go to STEP.
  - `run_i` wins over a same-cycle `step_i`.
- RUN / STEP:
  - `t` increments every clock.
  - On `last_tick`, `t` returns to 0 and `s` increments mod 8.
  - `clken_1` = active and `t` = 0.
  - `clken_2` = active and `t` = `CLK_DIV`.
  - `sync` = active and `s` = 7.
- RUN stop rule:
  - `stop_pending` is set on any clock in RUN where `halt_i` = 1 or `run_i` = 0.
  - It clears at `boundary`.
  - At `boundary`, go to HALTED if `stop_pending` (including this clock's set condition); otherwise stay in RUN.
- STEP: always goes to HALTED at `boundary`. `run_i` and `step_i` are ignored while in STEP; `halt_i` is also ignored, since STEP already ends at the boundary.
- `step_i` is ignored while in RUN.
- `icycle_cnt`:
  - increments by 1 at every `boundary`, in both RUN and STEP;
  - wraps from 2^`CNT_W`−1 to 0;
  - never resets except by `rst`.
- Reset (asserted at any time, including mid-subcycle):
  - next state HALTED, `t` = `s` = 0, `stop_pending` = 0, `icycle_cnt` = 0;
  - `clken_1` = `clken_2` = `sync` = `running` = 0, `subcycle` = 0.
  - A partially executed instruction cycle is abandoned; the first cycle after reset release starts at A1.

## Timing

- Start latency: `run_i` or `step_i` sampled in HALTED at edge N. State is RUN/STEP after edge N. `clken_1` is high in the clock after edge N, with `subcycle` = 0.
- Phase spacing within a subcycle: `clken_1` at tick 0, `clken_2` at tick `CLK_DIV`. The enables never coincide and are never asserted in HALTED.
- Instruction cycle length: 16·`CLK_DIV` clocks. With `CLK_DIV` = 1 this is 16 clocks, and `clken_1`/`clken_2` alternate every clock.
- `sync` width: 2·`CLK_DIV` clocks. It rises together with the X3 `clken_1` and falls when `subcycle` returns to 0 or the block halts.
- Stop: the last enable emitted is X3 `clken_2`. `running` falls on the clock after `boundary`. No further enables are emitted.
- Back-to-back operation: in RUN with no stop, A1 `clken_1` of the next cycle directly follows X3 `last_tick`, with no gap clock.
- Restart: the first possible restart is the clock after entering HALTED, because of the one-clock HALTED dwell.

## Test plan

- Reset then single step, `CLK_DIV` = 2: hold `rst` low, release, pulse `step_i` one clock.
  - Required: exactly 8 `clken_1` and 8 `clken_2` pulses, 4 clocks apart.
  - `sync` high for exactly 4 clocks.
  - Afterwards `running` = 0 and `icycle_cnt` = 1.
- Free run then halt mid-cycle, `CLK_DIV` = 1: raise `run_i`, then pulse `halt_i` during the M1 subcycle of cycle 3.
  - Required: cycle 3 completes through X3.
  - `running` drops 1 clock after the cycle-3 `boundary`.
  - `icycle_cnt` = 3.
- Simultaneous requests: from HALTED, assert `halt_i` = `run_i` = `step_i` = 1 in the same clock.
  - Required: stays HALTED, no enables.
  - Then `run_i` + `step_i` together (with `halt_i` = 0) → RUN, not STEP.
- Step ignored while running: pulse `step_i` during RUN; then drop `run_i` in X1.
  - Required: no extra cycle is inserted, and the halt lands at that cycle's `boundary`.
- Counter wrap: `CNT_W` = 4, run 17 cycles.
  - Required: `icycle_cnt` goes 15 → 0 → 1.
  - Final value is 1 with `running` = 0 after halting.
- Reset mid-subcycle: assert `rst` at `t` = 1 of subcycle X1.
  - Required: all outputs are 0 asynchronously, with no clock edge needed.
  - After release plus `run_i`, the first pulse is `clken_1` with `subcycle` = 0.
